// File: rtl/cmp_unit_seq.sv
// Multi-cycle compare/condition unit: walks the operands CHUNK bits per cycle, MSB chunk
// first, and returns a zero-extended boolean plus a constant-zero overflow flag.
module cmp_unit_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       mode,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             v
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = $clog2(NCHUNK + 1);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    // state | meaning
    // IDLE  | ready for a request
    // BUSY  | one operand chunk evaluated per cycle, top chunk first
    // DONE  | result held until the consumer takes it
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]      mode_q;
    logic            sign_q, amsb_q;
    logic            eq_q, az_q, lt_q, dec_q;
    logic [CW-1:0]   cnt_q;

    logic [CHUNK-1:0] a_raw, a_ch, b_ch;
    logic            eq_d, az_d, lt_d, dec_d, res_d, neg;

    assign in_ready = (state_q == IDLE);

    always_comb begin
        a_raw = a_q[WIDTH-1 -: CHUNK];
        a_ch  = a_raw;
        b_ch  = b_q[WIDTH-1 -: CHUNK];
        // Signed ordering: flip the sign bit of the top chunk so an unsigned compare works.
        if (sign_q && cnt_q == LAST) begin
            a_ch[CHUNK-1] = ~a_ch[CHUNK-1];
            b_ch[CHUNK-1] = ~b_ch[CHUNK-1];
        end
        eq_d  = eq_q & (a_ch == b_ch);
        az_d  = az_q & (a_raw == '0);
        lt_d  = lt_q;
        dec_d = dec_q;
        if (!dec_q && (a_ch != b_ch)) begin
            dec_d = 1'b1;
            lt_d  = (a_ch < b_ch);
        end
        neg   = sign_q & amsb_q;
        res_d = 1'b0;
        case (mode_q)
            3'd0:    res_d = eq_d;
            3'd1:    res_d = ~eq_d;
            3'd2:    res_d = lt_d;
            3'd3:    res_d = az_d | neg;
            3'd4:    res_d = ~az_d & ~neg;
            3'd5:    res_d = neg;
            3'd6:    res_d = ~neg;
            default: res_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            s         <= '0;
            v         <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            mode_q    <= '0;
            sign_q    <= 1'b0;
            amsb_q    <= 1'b0;
            eq_q      <= 1'b0;
            az_q      <= 1'b0;
            lt_q      <= 1'b0;
            dec_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        mode_q  <= mode;
                        sign_q  <= sign;
                        amsb_q  <= a[WIDTH-1];
                        eq_q    <= 1'b1;
                        az_q    <= 1'b1;
                        lt_q    <= 1'b0;
                        dec_q   <= 1'b0;
                        cnt_q   <= LAST;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    eq_q  <= eq_d;
                    az_q  <= az_d;
                    lt_q  <= lt_d;
                    dec_q <= dec_d;
                    a_q   <= a_q << CHUNK;
                    b_q   <= b_q << CHUNK;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        s         <= WIDTH'(res_d);
                        out_valid <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_unit_seq.sv
// Scoreboard bench for cmp_unit_seq: a 32/8 instance and a 16/16 instance checked
// against a signed/unsigned arithmetic reference model.
module tb_cmp_unit_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        iv32, ir32, ov32, or32, v32, sg32;
    logic [31:0] a32, b32, s32;
    logic [2:0]  m32;
    logic        iv16, ir16, ov16, or16, v16, sg16;
    logic [15:0] a16, b16, s16;
    logic [2:0]  m16;

    cmp_unit_seq #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .mode(m32), .sign(sg32), .out_valid(ov32), .out_ready(or32), .s(s32), .v(v32));

    cmp_unit_seq #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .mode(m16), .sign(sg16), .out_valid(ov16), .out_ready(or16), .s(s16), .v(v16));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          t;
    } exp_t;
    exp_t q32[$];
    exp_t q16[$];

    bit bp_hold = 1'b0;
    bit force_rdy = 1'b1;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: interpret operands as integers of width w, then apply the mode's rule.
    function automatic logic ref_res(input logic [31:0] a, input logic [31:0] b,
                                     input logic [2:0] m, input logic sg, input int w);
        longint va, vb;
        va = longint'({32'd0, a});
        vb = longint'({32'd0, b});
        if (sg) begin
            if (a[w-1]) va = va - (longint'(1) << w);
            if (b[w-1]) vb = vb - (longint'(1) << w);
        end
        case (m)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return va < vb;
            3'd3:    return va <= 0;
            3'd4:    return va > 0;
            3'd5:    return va < 0;
            3'd6:    return va >= 0;
            default: return 1'b0;
        endcase
    endfunction

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m,
                           input logic sg, input bit push);
        int n;
        a32 = a; b32 = b; m32 = m; sg32 = sg; iv32 = 1'b1;
        n = 0;
        while (!ir32 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ir32) begin
            chk("accept32_timeout", ir32, 1);
            iv32 = 1'b0;
            return;
        end
        if (push) q32.push_back('{32'(ref_res(a, b, m, sg, 32)), cyc + 1});
        @(posedge clk);
        @(negedge clk);
        iv32 = 1'b0;
        a32 = $urandom; b32 = $urandom; m32 = 3'($urandom); sg32 = 1'($urandom);
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic [2:0] m,
                           input logic sg);
        int n;
        a16 = a; b16 = b; m16 = m; sg16 = sg; iv16 = 1'b1;
        n = 0;
        while (!ir16 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ir16) begin
            chk("accept16_timeout", ir16, 1);
            iv16 = 1'b0;
            return;
        end
        q16.push_back('{32'(ref_res({16'd0, a}, {16'd0, b}, m, sg, 16)), cyc + 1});
        @(posedge clk);
        @(negedge clk);
        iv16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); m16 = 3'($urandom); sg16 = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q32.size() != 0 || q16.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", q32.size() + q16.size(), 0);
    endtask

    bit seen32 = 1'b0;
    always @(negedge clk) begin
        or32 = bp_hold ? 1'b0 : (force_rdy ? 1'b1 : ($urandom_range(0, 3) != 0));
        if (!reset && ov32) begin
            if (q32.size() == 0) begin
                chk("unexpected_valid32", ov32, 0);
            end else if (!seen32) begin
                chk("s32", s32, q32[0].res);
                chk("v32", v32, 0);
                chk("lat32", cyc - q32[0].t, 4);
                chk("in_ready_done32", ir32, 0);
                seen32 = 1'b1;
            end else begin
                chk("hold32", s32, q32[0].res);
            end
            if (or32) begin
                if (q32.size() != 0) void'(q32.pop_front());
                seen32 = 1'b0;
            end
        end
    end

    bit seen16 = 1'b0;
    always @(negedge clk) begin
        or16 = force_rdy ? 1'b1 : ($urandom_range(0, 3) != 0);
        if (!reset && ov16) begin
            if (q16.size() == 0) begin
                chk("unexpected_valid16", ov16, 0);
            end else if (!seen16) begin
                chk("s16", s16, q16[0].res);
                chk("v16", v16, 0);
                chk("lat16", cyc - q16[0].t, 1);
                seen16 = 1'b1;
            end else begin
                chk("hold16", s16, q16[0].res);
            end
            if (or16) begin
                if (q16.size() != 0) void'(q16.pop_front());
                seen16 = 1'b0;
            end
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  m;
        logic        sg;
    } op_t;

    op_t dir32[$] = '{
        '{32'h1234ABCD, 32'h1234ABCD, 3'd0, 1'b0},
        '{32'h1234ABCD, 32'h1234ABCC, 3'd0, 1'b0},
        '{32'h1234ABCD, 32'h1234ABCD, 3'd1, 1'b0},
        '{32'h1234ABCD, 32'h1234ABCC, 3'd1, 1'b0},
        '{32'hFFFFFFFF, 32'h00000001, 3'd2, 1'b1},
        '{32'hFFFFFFFF, 32'h00000001, 3'd2, 1'b0},
        '{32'h00FF0000, 32'h01000000, 3'd2, 1'b0},
        '{32'h80000000, 32'h0,        3'd3, 1'b0},
        '{32'h80000000, 32'h0,        3'd3, 1'b1},
        '{32'h00000000, 32'h5,        3'd3, 1'b0},
        '{32'h00000000, 32'h5,        3'd3, 1'b1},
        '{32'h00000005, 32'h0,        3'd4, 1'b1},
        '{32'h80000000, 32'h0,        3'd5, 1'b0},
        '{32'h80000000, 32'h0,        3'd6, 1'b1},
        '{32'h00000000, 32'h0,        3'd7, 1'b1}
    };

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, n, kind;
        logic [31:0] ra, rb;
        reset = 1'b1;
        iv32 = 0; a32 = 0; b32 = 0; m32 = 0; sg32 = 0;
        iv16 = 0; a16 = 0; b16 = 0; m16 = 0; sg16 = 0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", ov32, 0);
        chk("rst_s", s32, 0);
        chk("rst_v", v32, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", ir32, 1);
        chk("rst_in_ready16", ir16, 1);

        foreach (dir32[i]) issue32(dir32[i].a, dir32[i].b, dir32[i].m, dir32[i].sg, 1'b1);
        drain();

        // Backpressure: result must sit in DONE until released.
        @(posedge clk) bp_hold = 1'b1;
        @(negedge clk);
        issue32(32'h10, 32'h20, 3'd2, 1'b0, 1'b1);
        n = 0;
        while (!ov32 && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 10; k++) begin
            chk("bp_valid", ov32, 1);
            chk("bp_in_ready", ir32, 0);
            chk("bp_s", s32, 1);
            @(negedge clk);
        end
        @(posedge clk) bp_hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_ready", ir32, 1);
        chk("bp_idle_valid", ov32, 0);
        t0 = cyc;
        issue32(32'hFFFF0000, 32'hFFFF0000, 3'd0, 1'b1, 1'b1);
        chk("bp_next_accept", cyc - t0, 1);
        drain();

        // Reset during the second BUSY cycle discards the op.
        issue32(32'h00000001, 32'h00000002, 3'd2, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("rst_mid_valid", ov32, 0);
            chk("rst_mid_s", s32, 0);
            @(negedge clk);
        end
        issue32(32'h00000001, 32'h00000002, 3'd2, 1'b0, 1'b1);
        drain();

        // 16-bit single-chunk instance.
        issue16(16'h8000, 16'h7FFF, 3'd2, 1'b1);
        issue16(16'h8000, 16'h7FFF, 3'd2, 1'b0);
        issue16(16'h0000, 16'h0000, 3'd3, 1'b1);
        issue16(16'h8000, 16'h0000, 3'd6, 1'b1);
        drain();

        force_rdy = 1'b0;
        for (int k = 0; k < 60; k++) begin
            kind = $urandom_range(0, 3);
            ra = $urandom;
            rb = $urandom;
            if (kind == 1) rb = ra;
            if (kind == 2) rb = ra ^ (32'd1 << $urandom_range(0, 31));
            if (kind == 3) begin
                case ($urandom_range(0, 3))
                    0: ra = 32'h0;
                    1: ra = 32'h80000000;
                    2: ra = 32'h7FFFFFFF;
                    default: ra = 32'hFFFFFFFF;
                endcase
            end
            issue32(ra, rb, 3'($urandom_range(0, 7)), 1'($urandom), 1'b1);
        end
        for (int k = 0; k < 30; k++) begin
            kind = $urandom_range(0, 2);
            ra = $urandom;
            rb = $urandom;
            if (kind == 1) rb = ra;
            if (kind == 2) ra = {16'd0, ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h0000};
            issue16(ra[15:0], rb[15:0], 3'($urandom_range(0, 7)), 1'($urandom));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
